// File: rtl/caeco_sample_ingress.sv
// Multi-channel ECG sample ingress: register-window writes are sliced, packed
// round-robin into CHANNELS-wide frames and queued in a fall-through FIFO.

module caeco_ingress_lane #(
  parameter int SAMPLE_W = 16,
  parameter int LANE     = 0,
  parameter int CW       = 1
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic [CW-1:0]       ch_i,
  input  logic                wr_i,
  input  logic [SAMPLE_W-1:0] smp_i,
  input  logic                eor_i,
  output logic [SAMPLE_W-1:0] data_o,
  output logic                mask_o
);
  logic [SAMPLE_W-1:0] slot_q;
  logic                hit;

  assign hit = (ch_i == CW'(LANE));

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)          slot_q <= '0;
    else if (wr_i && hit) slot_q <= smp_i;
  end

  // Full frames bypass the slot for the lane being written this cycle;
  // EOR frames keep only slots below the channel counter.
  always_comb begin
    mask_o = 1'b1;
    data_o = hit ? smp_i : slot_q;
    if (eor_i) begin
      mask_o = (CW'(LANE) < ch_i);
      data_o = mask_o ? slot_q : '0;
    end
  end
endmodule

module caeco_sample_ingress #(
  parameter int CHANNELS  = 2,
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic                         clk,
  input  logic                         nRESET,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_addr,
  input  logic [31:0]                  wr_data,
  input  logic                         rd_en,
  input  logic [1:0]                   rd_addr,
  output logic [31:0]                  rd_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  output logic [CHANNELS-1:0]          frame_mask,
  output logic                         frame_last,
  output logic                         irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef struct packed {
    logic                               last;
    logic [CHANNELS-1:0]                mask;
    logic [CHANNELS-1:0][SAMPLE_W-1:0]  data;
  } frame_t;

  logic [31:0]         cmd_q, rd_q, status;
  logic [CW-1:0]       ch_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       lvl_q;
  logic                ovf_q, eor_q, irq_q;
  logic [SAMPLE_W-1:0] last_smp_q;
  frame_t              mem [DEPTH];
  frame_t              push_frm, head;

  logic [CHANNELS-1:0][SAMPLE_W-1:0] push_data;
  logic [CHANNELS-1:0]               push_mask;

  logic session, data_wr, cmd_wr, eor_evt, ch_last;
  logic push, pop, do_push, full, empty;

  assign session = cmd_q[4];
  assign data_wr = wr_en && (wr_addr == 2'd0) && session && cmd_q[0];
  assign cmd_wr  = wr_en && (wr_addr == 2'd1);
  assign eor_evt = cmd_wr && wr_data[3] && !cmd_q[3] && session;
  assign ch_last = (ch_q == CW'(CHANNELS - 1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    caeco_ingress_lane #(.SAMPLE_W(SAMPLE_W), .LANE(i), .CW(CW)) u_lane (
      .clk    (clk),
      .nRESET (nRESET),
      .ch_i   (ch_q),
      .wr_i   (data_wr),
      .smp_i  (wr_data[SAMPLE_W-1:0]),
      .eor_i  (eor_evt),
      .data_o (push_data[i]),
      .mask_o (push_mask[i])
    );
  end

  assign push_frm = '{last: eor_evt, mask: push_mask, data: push_data};

  assign full    = (lvl_q == LW'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign push    = (data_wr && ch_last) || eor_evt;
  assign pop     = frame_valid && frame_ready;
  assign do_push = push && (!full || pop);

  // Gating on session drops the head the cycle after SESSION is written to 0,
  // one cycle before the pointers themselves clear.
  assign frame_valid = session && !empty;
  assign head        = mem[rptr_q];
  assign frame_data  = frame_valid ? head.data : '0;
  assign frame_mask  = frame_valid ? head.mask : '0;
  assign frame_last  = frame_valid ? head.last : 1'b0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_frm;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ch_q   <= '0;
      ovf_q  <= 1'b0;
      eor_q  <= 1'b0;
    end else if (!session) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ch_q   <= '0;
      ovf_q  <= 1'b0;
      eor_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (eor_evt)      ch_q <= '0;
      else if (data_wr) ch_q <= ch_last ? '0 : ch_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (eor_evt)              eor_q <= 1'b1;
    end
  end

  always_comb begin
    status        = '0;
    status[7:0]   = 8'(lvl_q);
    status[8]     = empty;
    status[9]     = full;
    status[10]    = ovf_q;
    status[11]    = eor_q;
    status[14:12] = 3'(ch_q);
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cmd_q      <= '0;
      last_smp_q <= '0;
      rd_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (cmd_wr) cmd_q <= wr_data;
      if (wr_en && wr_addr == 2'd0) last_smp_q <= wr_data[SAMPLE_W-1:0];
      if (rd_en) begin
        case (rd_addr)
          2'd0:    rd_q <= 32'(last_smp_q);
          2'd1:    rd_q <= cmd_q;
          2'd2:    rd_q <= status;
          default: rd_q <= '0;
        endcase
      end
      irq_q <= (lvl_q >= LW'(IRQ_LEVEL)) | ovf_q | eor_q;
    end
  end

  assign rd_data = rd_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_caeco_sample_ingress.sv
// Directed bench for caeco_sample_ingress at default parameters
// (CHANNELS=2, SAMPLE_W=16, DEPTH=16, IRQ_LEVEL=8).

module tb_caeco_sample_ingress;
  logic        clk = 1'b0, nRESET = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, frame_ready = 1'b0;
  logic [1:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, frame_data;
  logic [1:0]  frame_mask;
  logic        frame_valid, frame_last, irq;
  int          total = 0, bad = 0;

  caeco_sample_ingress dut (
    .clk(clk), .nRESET(nRESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_mask(frame_mask),
    .frame_last(frame_last), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        is_rd;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        exp_fv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  function automatic logic [31:0] smp(input int k);
    return {16'hDEAD, 16'(16'h4000 + k * 3)};
  endfunction

  function automatic logic [31:0] frm(input int f);
    logic [31:0] a, b;
    a = smp(2 * f + 1);
    b = smp(2 * f);
    return {a[15:0], b[15:0]};
  endfunction

  task automatic pop_chk(input string nm, input logic [31:0] d, input logic [1:0] m, input logic l);
    chk({nm, "_valid"}, 64'(frame_valid), 64'd1);
    chk({nm, "_data"},  64'(frame_data),  64'(d));
    chk({nm, "_mask"},  64'(frame_mask),  64'(m));
    chk({nm, "_last"},  64'(frame_last),  64'(l));
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    //            is_rd addr  data           fv    rd
    vecs[0]  = '{1'b1, 2'd2, 32'h0,         1'b0, 32'h0000_0100};
    vecs[1]  = '{1'b1, 2'd1, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 2'd1, 32'h10,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 32'h11,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'h0,         1'b0, 32'h0000_0100};
    vecs[5]  = '{1'b0, 2'd1, 32'h11,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'd1, 32'h0,         1'b0, 32'h11};
    vecs[7]  = '{1'b0, 2'd0, 32'h1234,      1'b0, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 32'h0,         1'b0, 32'h0000_1100};
    vecs[9]  = '{1'b0, 2'd0, 32'hFFFF_ABCD, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 2'd0, 32'h0,         1'b1, 32'h0000_ABCD};
    vecs[11] = '{1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_0001};
    vecs[12] = '{1'b1, 2'd3, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b0, 2'd3, 32'hFFFF,      1'b1, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 32'hFFFF,      1'b1, 32'h0};
    vecs[15] = '{1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_0001};

    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data",  64'(frame_data),  64'd0);
    chk("rst_mask",  64'(frame_mask),  64'd0);
    chk("rst_last",  64'(frame_last),  64'd0);
    chk("rst_rd",    64'(rd_data),     64'd0);
    chk("rst_irq",   64'(irq),         64'd0);

    // Basic frame assembly, ignored writes, register readback.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_rd) begin
        rd(vecs[i].addr, r);
        chk($sformatf("vec%0d_rd", i), 64'(r), 64'(vecs[i].exp_rd));
      end else begin
        wr(vecs[i].addr, vecs[i].data);
      end
      chk($sformatf("vec%0d_fv", i), 64'(frame_valid), 64'(vecs[i].exp_fv));
    end
    chk("t1_irq", 64'(irq), 64'd0);
    pop_chk("t1_frame", 32'hABCD_1234, 2'b11, 1'b0);
    chk("t1_empty", 64'(frame_valid), 64'd0);

    // Overflow with a stalled consumer, irq latency at the threshold.
    for (int k = 0; k < 34; k++) begin
      wr(2'd0, smp(k));
      if (k == 15) chk("t3_irq_lat", 64'(irq), 64'd0);
      if (k == 16) chk("t3_irq_on",  64'(irq), 64'd1);
    end
    rd(2'd2, r);
    chk("t3_status_full", 64'(r), 64'h610);
    for (int f = 0; f < 16; f++) pop_chk($sformatf("t3_f%0d", f), frm(f), 2'b11, 1'b0);
    chk("t3_drained", 64'(frame_valid), 64'd0);
    rd(2'd2, r);
    chk("t3_status_ovf", 64'(r), 64'h500);
    chk("t3_irq_ovf", 64'(irq), 64'd1);

    // Partial frame at end of record.
    wr(2'd1, 32'h00);
    wr(2'd1, 32'h10);
    wr(2'd1, 32'h11);
    wr(2'd0, 32'hFFFF_1111);
    wr(2'd0, 32'hFFFF_2222);
    wr(2'd0, 32'hFFFF_3333);
    rd(2'd2, r);
    chk("t4_status_pre", 64'(r), 64'h1001);
    wr(2'd1, 32'h18);
    rd(2'd2, r);
    chk("t4_status_eor", 64'(r), 64'h802);
    chk("t4_irq", 64'(irq), 64'd1);
    pop_chk("t4_full", 32'h2222_1111, 2'b11, 1'b0);
    pop_chk("t4_part", 32'h0000_3333, 2'b01, 1'b1);
    chk("t4_empty", 64'(frame_valid), 64'd0);

    // Terminator frame, EOR acts on its rising edge only.
    wr(2'd1, 32'h10);
    wr(2'd1, 32'h18);
    pop_chk("t5_term", 32'h0, 2'b00, 1'b0 | 1'b1);
    wr(2'd1, 32'h18);
    chk("t5_no_reedge", 64'(frame_valid), 64'd0);
    rd(2'd1, r);
    chk("t5_cmd", 64'(r), 64'h18);

    // SESSION dropped with 5 frames queued and a partial frame pending.
    wr(2'd1, 32'h11);
    for (int k = 100; k < 111; k++) wr(2'd0, smp(k));
    rd(2'd2, r);
    chk("t6_status_pre", 64'(r), 64'h1805);
    chk("t6_irq_pre", 64'(irq), 64'd1);
    wr(2'd1, 32'h00);
    chk("t6_valid_drop", 64'(frame_valid), 64'd0);
    chk("t6_data_drop",  64'(frame_data),  64'd0);
    @(negedge clk);
    rd(2'd2, r);
    chk("t6_status_clr", 64'(r), 64'h100);
    chk("t6_irq_clr", 64'(irq), 64'd0);

    // Push and pop together while full: no overflow, order kept.
    wr(2'd1, 32'h10);
    wr(2'd1, 32'h11);
    for (int k = 0; k < 33; k++) wr(2'd0, smp(k));
    frame_ready = 1'b1;
    wr(2'd0, smp(33));
    frame_ready = 1'b0;
    rd(2'd2, r);
    chk("t6b_status_full", 64'(r), 64'h210);
    for (int f = 1; f < 17; f++) pop_chk($sformatf("t6b_f%0d", f), frm(f), 2'b11, 1'b0);
    chk("t6b_drained", 64'(frame_valid), 64'd0);
    rd(2'd2, r);
    chk("t6b_status_end", 64'(r), 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/caeco_sample_ingress.md
Name: caeco_sample_ingress

Overview:
Parametrised, multi-channel successor to the single-channel caeco sample input path. The MCU or the debug path writes 32-bit ECG samples and a command word through a small register window. The block slices each sample to SAMPLE_W bits and assembles CHANNELS samples round-robin into one frame. Frames are buffered in a DEPTH-entry FIFO and handed to the caeco datapath over a valid/ready stream, with end-of-record marking, sticky overflow and a fill-level interrupt.

Parameters:
CHANNELS, 2, samples per frame (1..8)
SAMPLE_W, 16, bits kept per sample (8..32); the low SAMPLE_W bits of wr_data are kept
DEPTH, 16, FIFO depth in frames; power of two, at least 2
IRQ_LEVEL, 8, fill level at which irq asserts (1..DEPTH)

Ports:
clk  in  1  system clock
nRESET  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe, one cycle
wr_addr  in  2  0=DATA, 1=CMD, 2=STATUS (read-only), 3=reserved
wr_data  in  32  write data
rd_en  in  1  register read strobe
rd_addr  in  2  register select
rd_data  out  32  read data, registered
frame_valid  out  1  FIFO head is valid
frame_ready  in  1  consumer accepts the head frame
frame_data  out  CHANNELS*SAMPLE_W  channel 0 in the LSBs
frame_mask  out  CHANNELS  1 = channel slot holds a real sample
frame_last  out  1  end-of-record frame
irq  out  1  level interrupt

Behaviour:
- Reset (async assert, sync deassert use): all of the following clear.
  - FIFO pointers and channel counter clear.
  - CMD=0, overflow=0, eor_done=0.
  - frame_valid=0, frame_data=0, frame_mask=0, frame_last=0, rd_data=0, irq=0.
- CMD bits:
  - bit4 SESSION. While 0, the block is held clear: FIFO emptied, partial frame discarded, overflow and eor_done cleared.
  - bit0 ACCEPT. DATA writes are taken only when SESSION=1 and ACCEPT=1; otherwise they are ignored silently.
  - bit3 EOR. Acts on its 0->1 write edge, and only when SESSION=1.
  - Other bits: read back as written, no effect.
  - Nominal write sequence: 0x00, 0x10, 0x11, samples, 0x18.
- DATA write:
  - wr_data[SAMPLE_W-1:0] is stored into the slot selected by the channel counter ch.
  - ch increments and wraps after CHANNELS-1.
  - When the slot for ch=CHANNELS-1 is filled, the frame is pushed in the same cycle with mask all ones and last=0.
- EOR edge:
  - If a partial frame is pending (ch != 0), it is pushed with unfilled slots = 0, mask = filled slots, last=1.
  - Otherwise a terminator frame is pushed with data=0, mask=0, last=1.
  - ch resets to 0, and eor_done sets (sticky).
- Push when FIFO full with no pop in the same cycle: the frame is dropped and overflow sets (sticky). ch still advances and wraps.
- Push and pop in the same cycle: both proceed, including when the FIFO is full; the level is unchanged.
- Output stream:
  - First-word fall-through: frame_valid rises the cycle after the first push into an empty FIFO.
  - frame_data, frame_mask and frame_last stay stable while frame_valid=1 and frame_ready=0.
  - A pop happens on frame_valid & frame_ready.
- STATUS word:
  - [7:0] fill level
  - [8] empty
  - [9] full
  - [10] overflow
  - [11] eor_done
  - [14:12] current ch
  - all other bits 0
- Reads: rd_data is updated one cycle after rd_en.
  - addr0 returns the last written sample, zero-extended from SAMPLE_W.
  - addr1 returns CMD.
  - addr2 returns STATUS.
  - addr3 returns 0.
  - Without rd_en, rd_data holds its value.
- irq = (level >= IRQ_LEVEL) | overflow | eor_done, registered with one cycle of latency.
- Writes to STATUS and reserved addresses are ignored.
- SESSION cleared mid-frame or mid-stream: the clear happens on the next cycle. frame_valid=0 the cycle after the CMD write, and any in-flight head frame is discarded.

Test Plan:
1. Reset, then CMD 0x10, 0x11; write 0x1234 and then 0xFFFF_ABCD (CHANNELS=2). One frame comes out with frame_data=0xABCD_1234, mask=2'b11, last=0. frame_valid goes high 1 cycle after the second write.
2. Write 0x11 to DATA while CMD=0x10. STATUS reads 0x00000100 (empty, ch=0) and no frame is produced.
3. Hold frame_ready=0 and write 2*(DEPTH+1) samples. STATUS shows full=1, level=16 and overflow=1; irq asserts once level>=8. After draining, exactly 16 frames come out in order.
4. Write 3 samples, then CMD 0x18. Two frames come out: the first with mask=11, last=0; the second with mask=01, data upper slot 0, last=1. STATUS shows eor_done=1.
5. Write CMD 0x18 with ch=0. A terminator frame comes out with mask=00, data=0, last=1.
6. With the FIFO holding 5 frames and ch=1, write CMD 0x00. The next cycle shows frame_valid=0, STATUS=0x00000100 and irq=0 one cycle later. Continuous frame_ready=1 with back-to-back pushes while full gives no overflow.
